// File: rtl/modexp_ctrl.sv
// modexp_ctrl: sequencer for left-to-right binary Montgomery exponentiation,
// result = X^E mod M, driving an external Montgomery multiplier.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start             begin request (accepted only in IDLE or DONE)
//   in_X, in_E        message and exponent (held stable by the host while busy)
//   in_E_ln           number of exponent bits to process, MSB first
//   in_RM, in_R2M     R mod M and R^2 mod M, R = 2^WIDTH
//   result, done      final value and completion level
//   mul_start         one-cycle launch pulse to the multiplier
//   mul_a, mul_b      multiplier operands, held until mul_done
//   mul_done          multiplier completion pulse, mul_result valid with it
//   mul_result        a*b*R^-1 mod M
module modexp_ctrl #(
    parameter int unsigned WIDTH = 1024,
    parameter int unsigned LEN_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in_X,
    input  logic [WIDTH-1:0] in_E,
    input  logic [LEN_W-1:0] in_E_ln,
    input  logic [WIDTH-1:0] in_RM,
    input  logic [WIDTH-1:0] in_R2M,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             mul_start,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    input  logic             mul_done,
    input  logic [WIDTH-1:0] mul_result
);

    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam logic [LEN_W-1:0] WIDTH_LEN = LEN_W'(WIDTH);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        StIdle,
        StConvX,
        StSquare,
        StMult,
        StConvOut,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   xt_q, xt_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   result_d;
    logic               done_d;
    logic               launch;
    logic [WIDTH-1:0]   op_a_d, op_b_d;
    logic [LEN_W-1:0]   e_len;
    logic               e_bit;

    assign e_len = (in_E_ln > WIDTH_LEN) ? WIDTH_LEN : in_E_ln;
    // idx never exceeds WIDTH-1 while squaring, so the low bits address in_E fully.
    assign e_bit = in_E[idx_q[IDX_W-1:0]];

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        xt_d     = xt_q;
        idx_d    = idx_q;
        result_d = result;
        done_d   = done;
        launch   = 1'b0;
        op_a_d   = mul_a;
        op_b_d   = mul_b;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    idx_d   = e_len;
                    done_d  = 1'b0;
                    state_d = StConvX;
                    launch  = 1'b1;
                    op_a_d  = in_X;
                    op_b_d  = in_R2M;
                end
            end
            StConvX: begin
                if (mul_done) begin
                    xt_d   = mul_result;
                    a_d    = in_RM;
                    launch = 1'b1;
                    op_a_d = in_RM;
                    if (idx_q != '0) begin
                        idx_d   = idx_q - 1'b1;
                        state_d = StSquare;
                        op_b_d  = in_RM;
                    end else begin
                        state_d = StConvOut;
                        op_b_d  = ONE;
                    end
                end
            end
            StSquare, StMult: begin
                if (mul_done) begin
                    a_d    = mul_result;
                    launch = 1'b1;
                    op_a_d = mul_result;
                    if (state_q == StSquare && e_bit) begin
                        // Multiply step for this bit; idx advances after it.
                        state_d = StMult;
                        op_b_d  = xt_q;
                    end else if (idx_q != '0) begin
                        idx_d   = idx_q - 1'b1;
                        state_d = StSquare;
                        op_b_d  = mul_result;
                    end else begin
                        state_d = StConvOut;
                        op_b_d  = ONE;
                    end
                end
            end
            StConvOut: begin
                if (mul_done) begin
                    result_d = mul_result;
                    done_d   = 1'b1;
                    state_d  = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            a_q       <= '0;
            xt_q      <= '0;
            idx_q     <= '0;
            result    <= '0;
            done      <= 1'b0;
            mul_start <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            xt_q      <= xt_d;
            idx_q     <= idx_d;
            result    <= result_d;
            done      <= done_d;
            mul_start <= launch;
            mul_a     <= op_a_d;
            mul_b     <= op_b_d;
        end
    end

endmodule

// File: doc/modexp_ctrl.md
# modexp_ctrl

Sequencing engine for left-to-right binary Montgomery modular exponentiation: result = X^E mod M. It sits directly downstream of the RSA top-level DMA/register block, which loads X, E, E length, R mod M and R² mod M and pulses `start`. The block drives a separate Montgomery multiplier through a start/done handshake. That multiplier takes the modulus M directly from the top-level register, so `modexp_ctrl` never sees M. Results return to the top level for DMA write-back.

## Interface
- `WIDTH`, default 1024: operand width in bits.
- `LEN_W`, default 32: width of the exponent-length input.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: one-cycle request to begin; sampled only in IDLE or DONE.
- `in_X`  in  WIDTH: message, integer < M.
- `in_E`  in  WIDTH: exponent; bit i is the weight 2^i.
- `in_E_ln`  in  LEN_W: number of exponent bits to process, starting at bit in_E_ln−1.
- `in_RM`  in  WIDTH: R mod M, with R = 2^WIDTH.
- `in_R2M`  in  WIDTH: R² mod M.
- `result`  out  WIDTH: X^E mod M; valid while `done`=1.
- `done`  out  1: level signal; high from completion until the next accepted `start`.
- `mul_start`  out  1: one-cycle pulse that launches a Montgomery multiply.
- `mul_a`, `mul_b`  out  WIDTH each: multiplier operands; stable from `mul_start` until `mul_done`.
- `mul_done`  in  1: one-cycle pulse; `mul_result` is valid in that same cycle.
- `mul_result`  in  WIDTH: MontMul(a,b) = a·b·R⁻¹ mod M.

## Operation
- Input stability: in_X, in_E, in_RM and in_R2M must stay stable from the accepted `start` until `done`. Only in_E_ln is captured.
- Internal registers:
  - A (WIDTH), the accumulator.
  - Xt (WIDTH), X in the Montgomery domain.
  - idx (LEN_W), the current exponent bit index.
- On an accepted start:
  - idx ← min(in_E_ln, WIDTH).
  - `done` ← 0.
  - Go to CONV_X.
- States and transitions:
  - IDLE: wait for `start`.
  - CONV_X: operands (in_X, in_R2M). On `mul_done`: Xt ← mul_result; A ← in_RM. Then go to SQUARE if idx ≠ 0, otherwise CONV_OUT. In the same transition, idx ← idx−1 when idx ≠ 0.
  - SQUARE: operands (A, A). On `mul_done`: A ← mul_result. Go to MULT if in_E[idx]=1. Otherwise go to SQUARE with idx ← idx−1 if idx ≠ 0, or to CONV_OUT if idx = 0.
  - MULT: operands (A, Xt). On `mul_done`: A ← mul_result. Go to SQUARE with idx ← idx−1 if idx ≠ 0, otherwise CONV_OUT.
  - CONV_OUT: operands (A, 1). On `mul_done`: result ← mul_result. Go to DONE.
  - DONE: `done`=1 and `result` is held. An accepted `start` restarts exactly as from IDLE.
- `mul_start` is high for exactly the first cycle of every CONV_X, SQUARE, MULT and CONV_OUT visit, including SQUARE→SQUARE re-entry. It is low in all other cycles.
- Operation count: N = 2 + L_e + popcount(in_E[L_e−1:0]), where L_e = min(in_E_ln, WIDTH).
- Boundary conditions:
  - in_E_ln = 0: result = 1 mod M (CONV_X then CONV_OUT).
  - in_E_ln > WIDTH: clamped to WIDTH.
  - Exponent bits at or above L_e are ignored.
  - `start` while busy (any state other than IDLE/DONE): ignored.
  - `mul_done` while in IDLE or DONE: ignored.
- Reset, asynchronous and including mid-operation:
  - state ← IDLE.
  - A, Xt, idx, result ← 0.
  - done, mul_start ← 0.
  - mul_a, mul_b ← 0.
  - A multiplier operation in flight is abandoned; its later `mul_done` is ignored.

## Timing
- Start is sampled at edge 0. CONV_X is entered in cycle 1, and `mul_start` is high in cycle 1.
- Let Lm ≥ 1 be the number of cycles from a `mul_start` cycle to its `mul_done` cycle. Each multiply state therefore occupies Lm+1 cycles.
- No idle cycles between operations.
- `done` rises at cycle 1 + N·(Lm+1).
- `result` updates on the same edge that `done` rises.
- Outputs are registered; no combinational path from `mul_done` to `mul_start`.

## Test plan
Bench settings for all scenarios: WIDTH=8, behavioural multiplier with Lm=3, M=13, R=256, in_RM=9, in_R2M=3.
- Basic exponentiation: X=5, E=0b11, E_ln=2 → result=8, N=6. `done` rises 25 cycles after the start edge; exactly 6 `mul_start` pulses.
- Zero-length exponent: X=5, E=0xFF, E_ln=0 → result=1, N=2, `done` at cycle 9. Also checks that bits at or above L_e are ignored.
- Single exponent bit: X=5, E=1, E_ln=1 → result=5, N=4, `done` at cycle 17.
- Length clamp: X=2, E=0x0C, E_ln=40 → clamped to 8, result=2^12 mod 13=1, N=12, `done` at cycle 49.
- Reset mid-operation: assert `reset` during the second SQUARE → same cycle, `done`=0, `mul_start`=0, result=0. After release, a fresh start with X=5, E=0b11, E_ln=2 again yields 8.
- Start while busy: a `start` pulse at cycle 10 of a run is ignored, with no timing change. A `start` while in DONE drops `done` on the next cycle and reruns the operation.
